// File: rtl/trig_record_reader.sv
// rtl/trig_record_reader.sv - read side of the trigger record ring, packs records into a 32-bit stream
// Optional start-time marker records: define TRIG_READER_START_TIME_EN.
module trig_record_reader #(
  parameter int          NREC   = 8,
  parameter int          TS_W   = 56,
  parameter logic [7:0]  HEADER = 8'hA5,
  localparam int         PW     = $clog2(NREC)
) (
  input  logic                   clk_adc,
  input  logic                   reset,
  input  logic                   resetClock,
  input  logic [NREC*8-1:0]      triggerFired,
  input  logic [NREC*TS_W-1:0]   clockCounter,
  input  logic [PW-1:0]          triggerCounter,
  input  logic [TS_W-1:0]        startTimeOut,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [PW:0]            occupancy,
  output logic                   overflow,
  output logic                   busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] W0      = 3'd2;
  localparam logic [2:0] W1      = 3'd3;
  localparam logic [2:0] W2      = 3'd4;
`ifdef TRIG_READER_START_TIME_EN
  localparam logic [2:0] S0      = 3'd5;
  localparam logic [2:0] S1      = 3'd6;
`endif

  logic [2:0]      state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   idx_q, idx_d;
  logic [7:0]      trig_q, trig_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [15:0]     seq_q, seq_d;
  logic            overflow_q;
  logic [PW:0]     occupancy_q;

  logic            accept;
  logic            pending;
  logic            pending_keep;
  logic            wr_adv;
  logic [PW-1:0]   occ_now;
  logic            lose;

`ifdef TRIG_READER_START_TIME_EN
  logic [TS_W-1:0]  st_prev_q;
  logic [TS_W-1:16] st_latest_q;
  logic [TS_W-1:16] st_emit_q;
  logic             sync_pend_q;
  logic             sync_take;
`else
  logic unused_start_time;
  assign unused_start_time = ^startTimeOut;
`endif

  assign accept  = out_valid & out_ready;
  assign pending = (rd_ptr_q != wr_q);
  assign wr_adv  = (triggerCounter != wr_q);
  assign occ_now = wr_q - rd_ptr_q;
  // A write into a ring that already holds NREC-1 unread records wraps the
  // pointer onto rd_ptr: everything unread is gone and the ring looks empty.
  // A capture in the same cycle frees a slot, so that case is not a loss.
  assign lose         = wr_adv && (occ_now == PW'(NREC - 1)) && (state_q != CAPTURE);
  assign pending_keep = pending && !lose;

  assign occupancy = occupancy_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

  // Next-state and capture logic for the record packer.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    trig_d   = trig_q;
    ts_d     = ts_q;
    seq_d    = seq_q;
`ifdef TRIG_READER_START_TIME_EN
    sync_take = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef TRIG_READER_START_TIME_EN
        if (sync_pend_q) begin
          state_d   = S0;
          sync_take = 1'b1;
        end else
`endif
        if (pending_keep) state_d = CAPTURE;
      end
      CAPTURE: begin
        trig_d   = triggerFired[32'(rd_ptr_q) * 8 +: 8];
        ts_d     = clockCounter[32'(rd_ptr_q) * TS_W +: TS_W];
        idx_d    = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = W0;
      end
      W0: if (accept) state_d = W1;
      W1: if (accept) state_d = W2;
      W2: begin
        if (accept) begin
          seq_d = seq_q + 16'd1;
`ifdef TRIG_READER_START_TIME_EN
          if (sync_pend_q) begin
            state_d   = S0;
            sync_take = 1'b1;
          end else
`endif
          if (pending_keep) state_d = CAPTURE;
          else              state_d = IDLE;
        end
      end
`ifdef TRIG_READER_START_TIME_EN
      S0: if (accept) state_d = S1;
      S1: begin
        if (accept) begin
          if (pending_keep) state_d = CAPTURE;
          else              state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Stream word selection; words are held by the registered state and data.
  always_comb begin
    out_data  = 32'h0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      W0: begin
        out_valid = 1'b1;
        out_data  = {HEADER, 5'b0, idx_q[2:0], trig_q, ts_q[TS_W-1 -: 8]};
      end
      W1: begin
        out_valid = 1'b1;
        out_data  = ts_q[47:16];
      end
      W2: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {ts_q[15:0], seq_q};
      end
`ifdef TRIG_READER_START_TIME_EN
      S0: begin
        out_valid = 1'b1;
        out_data  = {8'h5A, 16'b0, st_emit_q[TS_W-1 -: 8]};
      end
      S1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = st_emit_q[47:16];
      end
`endif
      default: ;
    endcase
  end

  // State registers; reset beats resetClock, and resetClock keeps seq running.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_q        <= '0;
      idx_q       <= '0;
      trig_q      <= '0;
      ts_q        <= '0;
      seq_q       <= '0;
      overflow_q  <= 1'b0;
      occupancy_q <= '0;
`ifdef TRIG_READER_START_TIME_EN
      st_prev_q   <= startTimeOut;
      st_latest_q <= '0;
      st_emit_q   <= '0;
      sync_pend_q <= 1'b0;
`endif
    end else if (resetClock) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_q        <= '0;
      overflow_q  <= 1'b0;
      occupancy_q <= '0;
`ifdef TRIG_READER_START_TIME_EN
      st_prev_q   <= startTimeOut;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_q        <= triggerCounter;
      idx_q       <= idx_d;
      trig_q      <= trig_d;
      ts_q        <= ts_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_q | lose;
      occupancy_q <= {1'b0, occ_now};
`ifdef TRIG_READER_START_TIME_EN
      st_prev_q <= startTimeOut;
      if (startTimeOut != st_prev_q) begin
        sync_pend_q <= 1'b1;
        st_latest_q <= startTimeOut[TS_W-1:16];
      end else if (sync_take) begin
        sync_pend_q <= 1'b0;
      end
      if (sync_take) st_emit_q <= st_latest_q;
`endif
    end
  end

endmodule
